idu_pipe: RTL and testbench

//   Parametrised, registered RISC-V decode stage between IFU and EXU. Decodes one
//   32-bit instruction per accepted beat into inst_num/type/regs/imm/shamt. Results
//   sit in a BUF_DEPTH-entry FIFO with valid/ready on both sides.
//   New features: XLEN 32/64, flush, illegal-instruction flag and backpressure.

---
 rtl/idu_pipe_pkg.sv | 95 +++++++++
 rtl/idu_pipe_dec.sv | 180 ++++++++++++++++++
 rtl/idu_pipe.sv | 90 +++++++++
 tb/tb_idu_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/idu_pipe_pkg.sv
// Package: idu_pipe_pkg
// Shared constants for the decode stage: field widths, instruction ids,
// instruction type codes, opcodes, and the width of one packed decoded entry.
// Optional feature macro used by importers: IDU_M_EXT_EN (adds the M-extension ids).
package idu_pipe_pkg;

    localparam int INST_NUM_WIDTH  = 6;
    localparam int INST_TYPE_WIDTH = 3;
    localparam int REG_ADDR_WIDTH  = 5;
    localparam int SHAMT_WIDTH     = 6;

    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_N = 3'd0;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_R = 3'd1;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_I = 3'd2;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_S = 3'd3;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_B = 3'd4;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_U = 3'd5;
    localparam logic [INST_TYPE_WIDTH-1:0] TYPE_J = 3'd6;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef logic [INST_NUM_WIDTH-1:0] inst_num_t;

    localparam inst_num_t INST_INV    = 6'd0;
    localparam inst_num_t INST_LUI    = 6'd1;
    localparam inst_num_t INST_AUIPC  = 6'd2;
    localparam inst_num_t INST_JAL    = 6'd3;
    localparam inst_num_t INST_JALR   = 6'd4;
    localparam inst_num_t INST_BEQ    = 6'd5;
    localparam inst_num_t INST_BNE    = 6'd6;
    localparam inst_num_t INST_BLT    = 6'd7;
    localparam inst_num_t INST_BGE    = 6'd8;
    localparam inst_num_t INST_BLTU   = 6'd9;
    localparam inst_num_t INST_BGEU   = 6'd10;
    localparam inst_num_t INST_LB     = 6'd11;
    localparam inst_num_t INST_LH     = 6'd12;
    localparam inst_num_t INST_LW     = 6'd13;
    localparam inst_num_t INST_LBU    = 6'd14;
    localparam inst_num_t INST_LHU    = 6'd15;
    localparam inst_num_t INST_SB     = 6'd16;
    localparam inst_num_t INST_SH     = 6'd17;
    localparam inst_num_t INST_SW     = 6'd18;
    localparam inst_num_t INST_ADDI   = 6'd19;
    localparam inst_num_t INST_SLTI   = 6'd20;
    localparam inst_num_t INST_SLTIU  = 6'd21;
    localparam inst_num_t INST_XORI   = 6'd22;
    localparam inst_num_t INST_ORI    = 6'd23;
    localparam inst_num_t INST_ANDI   = 6'd24;
    localparam inst_num_t INST_SLLI   = 6'd25;
    localparam inst_num_t INST_SRLI   = 6'd26;
    localparam inst_num_t INST_SRAI   = 6'd27;
    localparam inst_num_t INST_ADD    = 6'd28;
    localparam inst_num_t INST_SUB    = 6'd29;
    localparam inst_num_t INST_SLL    = 6'd30;
    localparam inst_num_t INST_SLT    = 6'd31;
    localparam inst_num_t INST_SLTU   = 6'd32;
    localparam inst_num_t INST_XOR    = 6'd33;
    localparam inst_num_t INST_SRL    = 6'd34;
    localparam inst_num_t INST_SRA    = 6'd35;
    localparam inst_num_t INST_OR     = 6'd36;
    localparam inst_num_t INST_AND    = 6'd37;
    localparam inst_num_t INST_FENCE  = 6'd38;
    localparam inst_num_t INST_ECALL  = 6'd39;
    localparam inst_num_t INST_EBREAK = 6'd40;
    // M-extension ids are contiguous in funct3 order: mul + funct3.
    localparam inst_num_t INST_MUL    = 6'd41;
    localparam inst_num_t INST_MULH   = 6'd42;
    localparam inst_num_t INST_MULHSU = 6'd43;
    localparam inst_num_t INST_MULHU  = 6'd44;
    localparam inst_num_t INST_DIV    = 6'd45;
    localparam inst_num_t INST_DIVU   = 6'd46;
    localparam inst_num_t INST_REM    = 6'd47;
    localparam inst_num_t INST_REMU   = 6'd48;

    // Packed entry: {pc, num, type, rd, rs1, rs2, imm, shamt, illegal}
    function automatic int entry_width(input int xlen);
        return 2 * xlen + INST_NUM_WIDTH + INST_TYPE_WIDTH + 3 * REG_ADDR_WIDTH
               + SHAMT_WIDTH + 1;
    endfunction

endpackage

// File: rtl/idu_pipe_dec.sv
// Module: idu_pipe_dec
// Purely combinational RISC-V decoder. Produces one packed entry
// {pc, num, type, rd, rs1, rs2, imm, shamt, illegal}.
// Optional macro IDU_M_EXT_EN: decode opcode OP with funct7=0000001 as mul..remu.
// Ports:
//   inst   in   32                   raw instruction
//   pc     in   XLEN                 pc of inst (passed through into the entry)
//   entry  out  entry_width(XLEN)    packed decode result
module idu_pipe_dec
    import idu_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]                  inst,
    input  logic [XLEN-1:0]              pc,
    output logic [entry_width(XLEN)-1:0] entry
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       shamt_ok;

    inst_num_t                  num;
    logic [INST_TYPE_WIDTH-1:0] typ_raw;
    logic [INST_TYPE_WIDTH-1:0] typ;
    logic                       illegal;
    logic [REG_ADDR_WIDTH-1:0]  rd;
    logic [REG_ADDR_WIDTH-1:0]  rs1;
    logic [REG_ADDR_WIDTH-1:0]  rs2;
    logic [31:0]                imm32;
    logic [XLEN-1:0]            imm;
    logic [SHAMT_WIDTH-1:0]     shamt;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];
    // On RV32 inst[25] would be shamt bit 5, which does not exist there.
    assign shamt_ok = (XLEN == 64) || !inst[25];

    always_comb begin
        num     = INST_INV;
        typ_raw = TYPE_N;
        case (opc)
            OPC_LUI:    begin num = INST_LUI;   typ_raw = TYPE_U; end
            OPC_AUIPC:  begin num = INST_AUIPC; typ_raw = TYPE_U; end
            OPC_JAL:    begin num = INST_JAL;   typ_raw = TYPE_J; end
            OPC_JALR: begin
                typ_raw = TYPE_I;
                if (f3 == 3'd0) num = INST_JALR;
            end
            OPC_BRANCH: begin
                typ_raw = TYPE_B;
                case (f3)
                    3'd0: num = INST_BEQ;
                    3'd1: num = INST_BNE;
                    3'd4: num = INST_BLT;
                    3'd5: num = INST_BGE;
                    3'd6: num = INST_BLTU;
                    3'd7: num = INST_BGEU;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                typ_raw = TYPE_I;
                case (f3)
                    3'd0: num = INST_LB;
                    3'd1: num = INST_LH;
                    3'd2: num = INST_LW;
                    3'd4: num = INST_LBU;
                    3'd5: num = INST_LHU;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                typ_raw = TYPE_S;
                case (f3)
                    3'd0: num = INST_SB;
                    3'd1: num = INST_SH;
                    3'd2: num = INST_SW;
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                typ_raw = TYPE_I;
                case (f3)
                    3'd0: num = INST_ADDI;
                    3'd2: num = INST_SLTI;
                    3'd3: num = INST_SLTIU;
                    3'd4: num = INST_XORI;
                    3'd6: num = INST_ORI;
                    3'd7: num = INST_ANDI;
                    3'd1: if (inst[31:26] == 6'b000000 && shamt_ok) num = INST_SLLI;
                    3'd5: begin
                        if (inst[31:26] == 6'b000000 && shamt_ok) num = INST_SRLI;
                        else if (inst[31:26] == 6'b010000 && shamt_ok) num = INST_SRAI;
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                typ_raw = TYPE_R;
                case (f7)
                    F7_BASE: begin
                        case (f3)
                            3'd0: num = INST_ADD;
                            3'd1: num = INST_SLL;
                            3'd2: num = INST_SLT;
                            3'd3: num = INST_SLTU;
                            3'd4: num = INST_XOR;
                            3'd5: num = INST_SRL;
                            3'd6: num = INST_OR;
                            default: num = INST_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (f3 == 3'd0) num = INST_SUB;
                        else if (f3 == 3'd5) num = INST_SRA;
                    end
`ifdef IDU_M_EXT_EN
                    F7_MULDIV: num = INST_MUL + inst_num_t'(f3);
`else
                    F7_MULDIV: ;
`endif
                    default: ;
                endcase
            end
            OPC_MISC_MEM: if (f3 == 3'd0) num = INST_FENCE;
            OPC_SYSTEM: begin
                if (inst == 32'h0000_0073) num = INST_ECALL;
                else if (inst == 32'h0010_0073) num = INST_EBREAK;
            end
            default: ;
        endcase
    end

    assign illegal = (num == INST_INV);
    // An illegal instruction carries no fields, so it is forced onto the N path.
    assign typ = illegal ? TYPE_N : typ_raw;

    always_comb begin
        rd    = '0;
        rs1   = '0;
        rs2   = '0;
        imm32 = '0;
        shamt = '0;
        case (typ)
            TYPE_R: begin rd = inst[11:7]; rs1 = inst[19:15]; rs2 = inst[24:20]; end
            TYPE_I: begin
                rd    = inst[11:7];
                rs1   = inst[19:15];
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            TYPE_S: begin
                rs1   = inst[19:15];
                rs2   = inst[24:20];
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            TYPE_B: begin
                rs1   = inst[19:15];
                rs2   = inst[24:20];
                imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            TYPE_U: begin rd = inst[11:7]; imm32 = {inst[31:12], 12'b0}; end
            TYPE_J: begin
                rd    = inst[11:7];
                imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: ;
        endcase
        if (num == INST_SLLI || num == INST_SRLI || num == INST_SRAI)
            shamt = (XLEN == 64) ? inst[25:20] : {1'b0, inst[24:20]};
    end

    // Every immediate is already sign-extended to 32 bits; widen by sign.
    assign imm = XLEN'($signed(imm32));

    assign entry = {pc, num, typ, rd, rs1, rs2, imm, shamt, illegal};

endmodule

// File: rtl/idu_pipe.sv
// Module: idu_pipe
// Registered RISC-V decode stage: decodes each accepted instruction and holds the
// results in a BUF_DEPTH-entry FIFO with valid/ready handshakes on both sides.
// Optional macro IDU_M_EXT_EN (passed to idu_pipe_dec): enables M-extension decode.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_inst/in_pc   IFU side
//   flush                             drop all buffered entries
//   out_valid/out_ready               EXU side handshake
//   out_pc, out_inst_num, out_inst_type, out_rd, out_rs1, out_rs2,
//   out_imm, out_shamt, out_illegal   head-of-FIFO decode fields
module idu_pipe
    import idu_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [INST_NUM_WIDTH-1:0]  out_inst_num,
    output logic [INST_TYPE_WIDTH-1:0] out_inst_type,
    output logic [REG_ADDR_WIDTH-1:0]  out_rd,
    output logic [REG_ADDR_WIDTH-1:0]  out_rs1,
    output logic [REG_ADDR_WIDTH-1:0]  out_rs2,
    output logic [XLEN-1:0]            out_imm,
    output logic [SHAMT_WIDTH-1:0]     out_shamt,
    output logic                       out_illegal
);

    localparam int ENTRY_W = entry_width(XLEN);
    localparam int PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [BUF_DEPTH];
    logic [ENTRY_W-1:0] dec_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    idu_pipe_dec #(.XLEN(XLEN)) u_dec (
        .inst  (in_inst),
        .pc    (in_pc),
        .entry (dec_entry)
    );

    // Ready depends only on the registered count (not on out_ready), so a full
    // buffer stays closed even in a cycle that pops.
    assign in_ready  = rst && (count < CNT_W'(BUF_DEPTH)) && !flush;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign {out_pc, out_inst_num, out_inst_type, out_rd, out_rs1, out_rs2,
            out_imm, out_shamt, out_illegal} = mem[rd_ptr];

endmodule

// File: tb/tb_idu_pipe.sv
module tb_idu_pipe;
    import idu_pipe_pkg::*;

    localparam int EW = entry_width(32);

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [5:0]  out_inst_num, out_shamt;
    logic [2:0]  out_inst_type;
    logic [4:0]  out_rd, out_rs1, out_rs2;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_pc64, out_imm64;
    logic [5:0]  out_inst_num64, out_shamt64;
    logic [2:0]  out_inst_type64;
    logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;

    int tests = 0;
    int fails = 0;
    logic [EW-1:0] sb_q [$];

    always #5 clk = ~clk;

    idu_pipe #(.XLEN(32), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst_num(out_inst_num), .out_inst_type(out_inst_type),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_shamt(out_shamt), .out_illegal(out_illegal)
    );

    idu_pipe #(.XLEN(64), .BUF_DEPTH(2)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_pc({32'h0, in_pc}), .flush(flush),
        .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
        .out_inst_num(out_inst_num64), .out_inst_type(out_inst_type64),
        .out_rd(out_rd64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64),
        .out_imm(out_imm64), .out_shamt(out_shamt64), .out_illegal(out_illegal64)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: a pop happens at the next edge whenever this holds.
    always @(negedge clk) begin
        if (rst && !flush && out_valid && out_ready) begin
            check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
            if (sb_q.size() != 0)
                check("head", {out_pc, out_inst_num, out_inst_type, out_rd, out_rs1,
                               out_rs2, out_imm, out_shamt, out_illegal},
                      sb_q.pop_front());
        end
    end

    task automatic send(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [5:0] num, input logic [2:0] typ,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [5:0] sh, input logic ill);
        bit ok = 0;
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back({pc, num, typ, rd, rs1, rs2, imm, sh, ill});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1;
            end
        end
        check("send_accepted", 128'(ok), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid && sb_q.size() == 0) done = 1;
        end
        check("drain_done", 128'(done), 128'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        check("post_rst_out_valid", 128'(out_valid), 128'(0));

        // addi x1,x2,-1
        send(32'hFFF1_0093, 32'h8000_0000, INST_ADDI, TYPE_I, 5'd1, 5'd2, 5'd0,
             32'hFFFF_FFFF, 6'd0, 1'b0);
        check("latency_valid", 128'(out_valid), 128'(1));
        check("addi_imm64", 128'(out_imm64), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        check("addi_pc64", 128'(out_pc64), 128'(64'h8000_0000));
        drain();

        // Mixed formats with concurrent push and pop.
        out_ready = 1'b1;
        send(32'h0073_02B3, 32'h100, INST_ADD,  TYPE_R, 5'd5, 5'd6, 5'd7, 32'h0, 6'd0, 1'b0);
        send(32'h0020_A423, 32'h104, INST_SW,   TYPE_S, 5'd0, 5'd1, 5'd2, 32'h8, 6'd0, 1'b0);
        send(32'hFE20_8EE3, 32'h108, INST_BEQ,  TYPE_B, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 6'd0, 1'b0);
        send(32'h1234_5537, 32'h10C, INST_LUI,  TYPE_U, 5'd10, 5'd0, 5'd0, 32'h1234_5000, 6'd0, 1'b0);
        send(32'h0080_00EF, 32'h110, INST_JAL,  TYPE_J, 5'd1, 5'd0, 5'd0, 32'h8, 6'd0, 1'b0);
        send(32'h0010_0073, 32'h114, INST_EBREAK, TYPE_N, 5'd0, 5'd0, 5'd0, 32'h0, 6'd0, 1'b0);
        send(32'hFFFF_FFFF, 32'h118, INST_INV,  TYPE_N, 5'd0, 5'd0, 5'd0, 32'h0, 6'd0, 1'b1);
        send(32'h4032_5213, 32'h11C, INST_SRAI, TYPE_I, 5'd4, 5'd4, 5'd0, 32'h403, 6'd3, 1'b0);
        drain();

        // Backpressure: two fill the buffer, the third is held.
        send(32'h0073_02B3, 32'h200, INST_ADD, TYPE_R, 5'd5, 5'd6, 5'd7, 32'h0, 6'd0, 1'b0);
        send(32'h0073_02B3, 32'h204, INST_ADD, TYPE_R, 5'd5, 5'd6, 5'd7, 32'h0, 6'd0, 1'b0);
        in_inst = 32'h0073_02B3; in_pc = 32'h208; in_valid = 1'b1;
        check("full_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        check("full_hold_in_ready", 128'(in_ready), 128'(0));
        check("full_hold_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        #1;
        check("full_pop_no_slot", 128'(in_ready), 128'(0));
        send(32'h0073_02B3, 32'h208, INST_ADD, TYPE_R, 5'd5, 5'd6, 5'd7, 32'h0, 6'd0, 1'b0);
        drain();

        // Flush with a push and a pop offered in the same cycle.
        send(32'h0073_02B3, 32'h300, INST_ADD, TYPE_R, 5'd5, 5'd6, 5'd7, 32'h0, 6'd0, 1'b0);
        send(32'h0073_02B3, 32'h304, INST_ADD, TYPE_R, 5'd5, 5'd6, 5'd7, 32'h0, 6'd0, 1'b0);
        in_inst = 32'hFFF1_0093; in_pc = 32'h308; in_valid = 1'b1;
        flush = 1'b1; out_ready = 1'b1;
        sb_q.delete();
        #1;
        check("flush_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_in_ready_after", 128'(in_ready), 128'(1));
        send(32'h0010_0073, 32'h400, INST_EBREAK, TYPE_N, 5'd0, 5'd0, 5'd0, 32'h0, 6'd0, 1'b0);
        drain();

        // slli with shamt bit 5 set: illegal on RV32, shamt=32 on RV64.
        send(32'h0200_9093, 32'h500, INST_INV, TYPE_N, 5'd0, 5'd0, 5'd0, 32'h0, 6'd0, 1'b1);
        check("slli64_num", 128'(out_inst_num64), 128'(INST_SLLI));
        check("slli64_shamt", 128'(out_shamt64), 128'(32));
        check("slli64_illegal", 128'(out_illegal64), 128'(0));
        check("slli64_rd_rs1", 128'({out_rd64, out_rs1_64}), 128'({5'd1, 5'd1}));
        drain();

        // mul x3,x1,x2
`ifdef IDU_M_EXT_EN
        send(32'h0220_81B3, 32'h600, INST_MUL, TYPE_R, 5'd3, 5'd1, 5'd2, 32'h0, 6'd0, 1'b0);
`else
        send(32'h0220_81B3, 32'h600, INST_INV, TYPE_N, 5'd0, 5'd0, 5'd0, 32'h0, 6'd0, 1'b1);
`endif
        drain();

        // Reset mid-stream with two entries buffered.
        send(32'h0073_02B3, 32'h700, INST_ADD, TYPE_R, 5'd5, 5'd6, 5'd7, 32'h0, 6'd0, 1'b0);
        send(32'h1234_5537, 32'h704, INST_LUI, TYPE_U, 5'd10, 5'd0, 5'd0, 32'h1234_5000, 6'd0, 1'b0);
        check("pre_rst_full", 128'(in_ready), 128'(0));
        rst = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(0));
        check("midrst_fields", {out_pc, out_inst_num, out_inst_type, out_rd, out_rs1,
                                out_rs2, out_imm, out_shamt, out_illegal}, 128'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_release_ready", 128'(in_ready), 128'(1));
        check("midrst_release_valid", 128'(out_valid), 128'(0));
        send(32'h0080_00EF, 32'h800, INST_JAL, TYPE_J, 5'd1, 5'd0, 5'd0, 32'h8, 6'd0, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
